// File: rtl/spad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spad_ctrl_pkg
// Shared types for the scratchpad access controller.
//   spad_ctrl_state_e : controller FSM states
//   spad_cmd_t        : fill/drain command {write, base_addr, len}
//   read_slot_free()  : drain-side credit check against the 2-entry skid FIFO
// SPAD_ADDR_BITWIDTH sizes spad_cmd_t and is the default SPad geometry of
// spad_access_ctrl; change both together when building a deeper SPad.
// -----------------------------------------------------------------------------
package spad_ctrl_pkg;

   localparam int SPAD_ADDR_BITWIDTH = 9;
   localparam int SPAD_DATA_BITWIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_FIN   = 3'd4
   } spad_ctrl_state_e;

   typedef struct packed {
      logic                          write;
      logic [SPAD_ADDR_BITWIDTH-1:0] base_addr;
      logic [SPAD_ADDR_BITWIDTH:0]   len;
   } spad_cmd_t;

   // A new read may be issued when the words already owed to the FIFO
   // (stored + in flight), less the one leaving this cycle, leave room for it.
   function automatic logic read_slot_free(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       pop);
      logic [2:0] pending;
      pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      return (pending < 3'd2);
   endfunction

endpackage

// File: rtl/spad_rd_skid_fifo.sv
// -----------------------------------------------------------------------------
// spad_rd_skid_fifo
// Two-entry FIFO that catches SPad read data so the drain stream can stall
// without losing a word already requested from the SPad.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   push, push_data   write one word (ignored when full and not popping)
//   pop               remove the head word (ignored when empty)
//   head_data         current head word, 0 when empty
//   full, empty       occupancy flags
//   count             occupancy 0..2
// -----------------------------------------------------------------------------
module spad_rd_skid_fifo #(
   parameter int DATA_BITWIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_BITWIDTH-1:0] push_data,
   input  logic                     pop,
   output logic [DATA_BITWIDTH-1:0] head_data,
   output logic                     full,
   output logic                     empty,
   output logic [1:0]               count
);

   logic [DATA_BITWIDTH-1:0] mem_q [2];
   logic                     wr_ptr_q;
   logic                     rd_ptr_q;
   logic [1:0]               count_q;
   logic                     push_ok_s;
   logic                     pop_ok_s;

   assign pop_ok_s  = pop && (count_q != 2'd0);
   assign push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok_s) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok_s)  rd_ptr_q <= ~rd_ptr_q;
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q[0] <= {DATA_BITWIDTH{1'b0}};
         mem_q[1] <= {DATA_BITWIDTH{1'b0}};
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign full      = (count_q == 2'd2);
   assign empty     = (count_q == 2'd0);
   assign count     = count_q;
   assign head_data = empty ? {DATA_BITWIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/spad_access_ctrl.sv
// -----------------------------------------------------------------------------
// spad_access_ctrl
// Initiator side of a per-PE scratchpad port. Fill commands stream words from a
// valid/ready source into consecutive SPad addresses; drain commands read
// consecutive addresses and emit them on a valid/ready sink in address order.
// The SPad's 1-cycle read latency is absorbed by a 2-entry skid FIFO, and the
// read bus is sampled only in the cycle after a request, so its idle value is
// never forwarded.
// Ports:
//   clk, reset                   clock; synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_write                    1 = fill, 0 = drain
//   cmd_base_addr, cmd_len       first address, word count 0..2**ADDR_BITWIDTH
//   wr_valid/wr_ready/wr_data    fill source stream
//   rd_valid/rd_ready/rd_data    drain sink stream
//   spad_read_request/_addr      SPad read port
//   spad_write_enable/_addr/_data SPad write port
//   spad_read_data               SPad read data, valid 1 cycle after request
//   busy, done                   not idle; 1-cycle completion pulse
// Optional feature (macro SPAD_ACCESS_PERF_EN): adds saturating counters
//   perf_words (words moved either way) and perf_stall (sink stall cycles).
// -----------------------------------------------------------------------------
module spad_access_ctrl
   import spad_ctrl_pkg::*;
#(
   parameter int DATA_BITWIDTH = SPAD_DATA_BITWIDTH,
   parameter int ADDR_BITWIDTH = SPAD_ADDR_BITWIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDR_BITWIDTH-1:0] cmd_base_addr,
   input  logic [ADDR_BITWIDTH:0]   cmd_len,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATA_BITWIDTH-1:0] wr_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_BITWIDTH-1:0] rd_data,
   output logic                     spad_read_request,
   output logic [ADDR_BITWIDTH-1:0] spad_read_addr,
   output logic                     spad_write_enable,
   output logic [ADDR_BITWIDTH-1:0] spad_write_addr,
   output logic [DATA_BITWIDTH-1:0] spad_write_data,
   input  logic [DATA_BITWIDTH-1:0] spad_read_data,
   output logic                     busy,
   output logic                     done
`ifdef SPAD_ACCESS_PERF_EN
   ,
   output logic [31:0]              perf_words,
   output logic [31:0]              perf_stall
`endif
);

   localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE  = ADDR_BITWIDTH'(1);
   localparam logic [ADDR_BITWIDTH-1:0] ADDR_ZERO = ADDR_BITWIDTH'(0);
   localparam logic [ADDR_BITWIDTH:0]   REM_ONE   = (ADDR_BITWIDTH + 1)'(1);
   localparam logic [ADDR_BITWIDTH:0]   REM_ZERO  = (ADDR_BITWIDTH + 1)'(0);
   localparam logic [DATA_BITWIDTH-1:0] DATA_ZERO = DATA_BITWIDTH'(0);

   spad_ctrl_state_e         state_q, state_d;
   logic [ADDR_BITWIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_BITWIDTH:0]   rem_q, rem_d;
   logic                     inflight_q;
   logic                     done_q;

   spad_cmd_t                cmd_s;
   logic                     cmd_fire_s;
   logic                     we_s;
   logic                     rd_req_s;
   logic                     rd_fire_s;
   logic                     slot_free_s;
   logic [1:0]               fifo_count_s;
   logic                     fifo_full_s;
   logic                     fifo_empty_s;
   logic [DATA_BITWIDTH-1:0] fifo_head_s;

   // Command view of the input ports.
   always_comb begin
      cmd_s.write     = cmd_write;
      cmd_s.base_addr = SPAD_ADDR_BITWIDTH'(cmd_base_addr);
      cmd_s.len       = (SPAD_ADDR_BITWIDTH + 1)'(cmd_len);
   end

   assign cmd_fire_s  = cmd_valid && (state_q == ST_IDLE);
   assign rd_fire_s   = !fifo_empty_s && rd_ready;
   // Counting this cycle's pop keeps the drain at one word per clock; it makes
   // the read request depend combinationally on rd_ready.
   assign slot_free_s = read_slot_free(fifo_count_s, inflight_q, rd_fire_s);

   // Next-state, pointer and remaining-count logic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      rem_d    = rem_q;
      we_s     = 1'b0;
      rd_req_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               ptr_d = ADDR_BITWIDTH'(cmd_s.base_addr);
               rem_d = (ADDR_BITWIDTH + 1)'(cmd_s.len);
               if (cmd_s.len == (SPAD_ADDR_BITWIDTH + 1)'(0)) begin
                  state_d = ST_FIN;
               end else if (cmd_s.write) begin
                  state_d = ST_FILL;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (wr_valid) begin
               we_s    = 1'b1;
               ptr_d   = ptr_q + ADDR_ONE;
               rem_d   = rem_q - REM_ONE;
               state_d = (rem_q == REM_ONE) ? ST_FIN : ST_FILL;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DRAIN: begin
            if ((rem_q != REM_ZERO) && slot_free_s) begin
               rd_req_s = 1'b1;
               ptr_d    = ptr_q + ADDR_ONE;
               rem_d    = rem_q - REM_ONE;
               state_d  = (rem_q == REM_ONE) ? ST_FLUSH : ST_DRAIN;
            end else if (rem_q == REM_ZERO) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_FLUSH: begin
            if (!inflight_q && fifo_empty_s) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state registers; done is the registered echo of FIN.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= ADDR_ZERO;
         rem_q      <= REM_ZERO;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         inflight_q <= rd_req_s;
         done_q     <= (state_q == ST_FIN);
      end
   end

   // Read data is pushed only in the cycle after a request; any other bus value is dropped.
   spad_rd_skid_fifo #(
      .DATA_BITWIDTH (DATA_BITWIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (spad_read_data),
      .pop       (rd_fire_s),
      .head_data (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   assign cmd_ready         = (state_q == ST_IDLE);
   assign busy              = (state_q != ST_IDLE);
   assign done              = done_q;
   assign wr_ready          = (state_q == ST_FILL);
   assign rd_valid          = !fifo_empty_s;
   assign rd_data           = fifo_head_s;
   assign spad_read_request = rd_req_s;
   assign spad_read_addr    = rd_req_s ? ptr_q : ADDR_ZERO;
   assign spad_write_enable = we_s;
   assign spad_write_addr   = we_s ? ptr_q : ADDR_ZERO;
   assign spad_write_data   = we_s ? wr_data : DATA_ZERO;

`ifdef SPAD_ACCESS_PERF_EN
   logic [31:0] perf_words_q;
   logic [31:0] perf_stall_q;
   logic        stall_s;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
   endfunction

   assign stall_s = ((state_q == ST_DRAIN) || (state_q == ST_FLUSH)) &&
                    !fifo_empty_s && !rd_ready;

   // Saturating transfer and sink-stall counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_words_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_words_q <= sat_inc(perf_words_q, we_s || rd_fire_s);
         perf_stall_q <= sat_inc(perf_stall_q, stall_s);
      end
   end

   assign perf_words = perf_words_q;
   assign perf_stall = perf_stall_q;
`else
   logic unused_s;
   assign unused_s = fifo_full_s;
`endif

endmodule

// File: tb/tb_spad_access_ctrl.sv
// Scoreboard bench for spad_access_ctrl: stimulus pushes expected SPad writes
// and drain words into queues; a negedge monitor pops and compares them.
module tb_spad_access_ctrl;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam logic [DW-1:0] IDLE_BUS = 16'hDEAD;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_base_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b1;
   logic [DW-1:0] rd_data;
   logic          spad_read_request;
   logic [AW-1:0] spad_read_addr;
   logic          spad_write_enable;
   logic [AW-1:0] spad_write_addr;
   logic [DW-1:0] spad_write_data;
   logic [DW-1:0] spad_read_data;
   logic          busy;
   logic          done;
`ifdef SPAD_ACCESS_PERF_EN
   logic [31:0]   perf_words;
   logic [31:0]   perf_stall;
`endif

   always #5 clk = ~clk;

   spad_access_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_write         (cmd_write),
      .cmd_base_addr     (cmd_base_addr),
      .cmd_len           (cmd_len),
      .wr_valid          (wr_valid),
      .wr_ready          (wr_ready),
      .wr_data           (wr_data),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .rd_data           (rd_data),
      .spad_read_request (spad_read_request),
      .spad_read_addr    (spad_read_addr),
      .spad_write_enable (spad_write_enable),
      .spad_write_addr   (spad_write_addr),
      .spad_write_data   (spad_write_data),
      .spad_read_data    (spad_read_data),
      .busy              (busy),
      .done              (done)
`ifdef SPAD_ACCESS_PERF_EN
      ,
      .perf_words        (perf_words),
      .perf_stall        (perf_stall)
`endif
   );

   // SPad model: single-cycle write, 1-cycle read latency, idle bus value otherwise.
   logic [DW-1:0] mem [512];
   always @(posedge clk) begin
      if (spad_write_enable) mem[spad_write_addr] <= spad_write_data;
      spad_read_data <= spad_read_request ? mem[spad_read_addr] : IDLE_BUS;
   end

   int checks = 0;
   int errors = 0;
   logic [DW-1:0]      ref_mem [512];
   logic [DW-1:0]      words [8];
   logic [DW-1:0]      rd_exp [$];
   logic [AW+DW-1:0]   wr_exp [$];
   int pop_log [$];
   int ncyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, exp_done = 0;
   int req_cnt = 0, we_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic flag_fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: actual=event missing required=event seen", nm);
   endtask

   // Monitor: scoreboard pops and per-cycle bus checks.
   always @(negedge clk) begin
      ncyc++;
      if (reset) begin
         if (cmd_valid && cmd_ready) acc_cyc = ncyc;
         if (done) begin
            done_cnt++;
            done_cyc = ncyc;
         end
         if (spad_read_request) req_cnt++;
         if (spad_write_enable) begin
            we_cnt++;
            if (wr_exp.size() == 0) flag_fail("unexpected_spad_write");
            else chk("spad_write{addr,data}", 32'({spad_write_addr, spad_write_data}), 32'(wr_exp.pop_front()));
         end
         if (rd_valid && rd_ready) begin
            pop_log.push_back(ncyc);
            if (rd_exp.size() == 0) flag_fail("unexpected_rd_word");
            else chk("rd_data", 32'(rd_data), 32'(rd_exp.pop_front()));
         end
         chk("req_we_exclusive", 32'(spad_read_request & spad_write_enable), 32'd0);
      end
   end

   task automatic send_cmd(input logic w, input logic [AW-1:0] base, input logic [AW:0] len);
      int t = 0;
      while (!cmd_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      if (!cmd_ready) flag_fail("cmd_ready_timeout");
      cmd_valid = 1'b1; cmd_write = w; cmd_base_addr = base; cmd_len = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 300) begin
         @(posedge clk); #1; t++;
      end
      if (busy) flag_fail("busy_timeout");
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_fill(input logic [AW-1:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         ref_mem[AW'(base + i)] = words[i];
         wr_exp.push_back({AW'(base + i), words[i]});
      end
      exp_done++;
      send_cmd(1'b1, base, (AW+1)'(len));
      chk("wr_ready_in_fill", 32'(wr_ready), 32'd1);
      for (int i = 0; i < len; i++) begin
         wr_valid = 1'b1; wr_data = words[i];
         @(posedge clk); #1;
      end
      wr_valid = 1'b0; wr_data = '0;
      wait_idle();
      chk("fill_writes_left", 32'(wr_exp.size()), 32'd0);
      chk("fill_done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   // mode 0: sink always ready; mode 1: rd_ready pattern 1,0,0 repeating.
   task automatic do_drain(input logic [AW-1:0] base, input int len, input int mode);
      int t = 0;
      for (int i = 0; i < len; i++) rd_exp.push_back(ref_mem[AW'(base + i)]);
      exp_done++;
      rd_ready = 1'b1;
      send_cmd(1'b0, base, (AW+1)'(len));
      while (busy && t < 300) begin
         rd_ready = (mode == 1) ? ((t % 3) == 0) : 1'b1;
         @(posedge clk); #1; t++;
      end
      rd_ready = 1'b1;
      wait_idle();
      chk("drain_words_left", 32'(rd_exp.size()), 32'd0);
      chk("drain_done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   initial begin
      int r0, w0, t;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_read_request", 32'(spad_read_request), 32'd0);
      chk("rst_write_enable", 32'(spad_write_enable), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: fill 1..4 at 0, drain back at full rate
      words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003; words[3] = 16'h0004;
      do_fill(9'd0, 4);
      pop_log.delete();
      do_drain(9'd0, 4, 0);
      chk("t1_pop_count", 32'(pop_log.size()), 32'd4);
      if (pop_log.size() == 4) chk("t1_consecutive", 32'(pop_log[3] - pop_log[0]), 32'd3);

      // 2: drain with stalling sink
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
      words[4] = 16'h5555; words[5] = 16'h6666;
      do_fill(9'd40, 6);
      do_drain(9'd40, 6, 1);

      // 3: wrap-around fill/drain; writes must land at 510, 511, 0, 1
      words[0] = 16'hA0A0; words[1] = 16'hB1B1; words[2] = 16'hC2C2; words[3] = 16'hD3D3;
      do_fill(9'd510, 4);
      chk("t3_mem0", 32'(mem[0]), 32'h0000C2C2);
      chk("t3_mem511", 32'(mem[511]), 32'h0000B1B1);
      do_drain(9'd510, 4, 1);

      // 4: zero-length command
      r0 = req_cnt; w0 = we_cnt;
      exp_done++;
      send_cmd(1'b0, 9'd7, 10'd0);
      t = 0;
      while (done_cnt != exp_done && t < 20) begin
         @(posedge clk); #1; t++;
      end
      chk("t4_done_count", 32'(done_cnt), 32'(exp_done));
      chk("t4_done_latency", 32'(done_cyc - acc_cyc), 32'd2);
      chk("t4_no_read_req", 32'(req_cnt), 32'(r0));
      chk("t4_no_write", 32'(we_cnt), 32'(w0));
      chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);

      // 5: reset mid-drain, then a normal fill
      for (int i = 0; i < 8; i++) words[i] = 16'h0010 + 16'(i);
      do_fill(9'd0, 8);
      for (int i = 0; i < 8; i++) rd_exp.push_back(ref_mem[i]);
      pop_log.delete();
      rd_ready = 1'b1;
      send_cmd(1'b0, 9'd0, 10'd8);
      t = 0;
      while (pop_log.size() < 3 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (pop_log.size() < 3) flag_fail("t5_three_words");
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_rd_valid", 32'(rd_valid), 32'd0);
      chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t5_done", 32'(done), 32'd0);
      reset = 1'b1;
      rd_exp.delete();
      repeat (4) @(posedge clk);
      #1;
      chk("t5_no_done_pulse", 32'(done_cnt), 32'(exp_done));
      words[0] = 16'h7A01; words[1] = 16'h7A02; words[2] = 16'h7A03;
      do_fill(9'd100, 3);
      do_drain(9'd100, 3, 0);

`ifdef SPAD_ACCESS_PERF_EN
      // 6: perf counters, 4 in + 4 out with exactly 3 stall cycles
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      words[0] = 16'h0C01; words[1] = 16'h0C02; words[2] = 16'h0C03; words[3] = 16'h0C04;
      do_fill(9'd20, 4);
      for (int i = 0; i < 4; i++) rd_exp.push_back(ref_mem[20 + i]);
      exp_done++;
      rd_ready = 1'b1;
      send_cmd(1'b0, 9'd20, 10'd4);
      t = 0;
      while (!rd_valid && t < 20) begin
         @(posedge clk); #1; t++;
      end
      rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd_ready = 1'b1;
      wait_idle();
      chk("t6_words_left", 32'(rd_exp.size()), 32'd0);
      chk("t6_perf_words", perf_words, 32'd8);
      chk("t6_perf_stall", perf_stall, 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=still running required=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
